scan_chain_driver: RTL
======================

// Module: scan_chain_driver
// PURPOSE
//  Scan-test initiator for a mux-scan chain whose ports are tms (scan enable), tdi (scan in) and tdo (scan out).
//  Loads an N-bit pattern into the chain, optionally pulses one functional capture, and unloads N bits.
//  Compares the unloaded bits against an expected vector under a mask and reports pass/fail.
//  Sits on the tester side of the chain: drives the chain's tms/tdi and samples its tdo.
// PARAMETERS
//  CHAIN_LEN  3  number of scan flops in the chain (N); legal range is N>=1
//  CW  $clog2(CHAIN_LEN+1)  width of the bit counter; derived, do not override
// PORTS
//  Clk       in   1  single clock; the same clock drives the chain
//  ClrN      in   1  asynchronous active-low reset
//  start     in   1  request one test; accepted only when ready=1
//  cap_en    in   1  1: shift-capture-unload; 0: shift-through (chain integrity)
//  pattern   in   N  load vector; after load, chain flop k (k=0 nearest tdi) holds pattern[k]
//  expected  in   N  expected response, same bit indexing as pattern
//  mask      in   N  1 = compare this bit; 0 = don't-care
//  ready     out  1  high in IDLE only
//  tms       out  1  registered scan enable to the chain
//  tdi       out  1  registered scan data to the chain
//  tdo       in   1  scan data from the last chain flop (k=N-1)
//  response  out  N  unloaded vector; response[k] = the value flop k held before unload
//  done      out  1  one-cycle pulse when response/pass are valid
//  pass      out  1  ((response ^ expected) & mask) == 0; held until the next accept
// BEHAVIOUR
//  Reset (ClrN=0, async): state=IDLE; ready=1; tms=0; tdi=0; done=0; pass=0; response=0; counter=0.
//  All outputs are driven from flops; there is no combinational path from an input to an output.
//  Accept: rising edge E0 with start=1 & ready=1 latches pattern/expected/mask/cap_en.
//   The state then goes to SHIFT_IN and ready drops. Inputs are don't-care after E0.
//  FSM: IDLE -> SHIFT_IN -> [CAPTURE if cap_en] -> SHIFT_OUT -> DONE -> IDLE.
//  SHIFT_IN, cycles 1..N after E0:
//   - tms=1; tdi in cycle j = pattern[N-j], so pattern[N-1] is sent first.
//   - The chain shifts on edges E1..EN.
//  CAPTURE, cycle N+1, only when cap_en=1: tms=0, tdi=0; the chain loads its functional D inputs on edge E(N+1).
//  SHIFT_OUT, next N cycles (C = 1 if cap_en else 0):
//   - tms=1, tdi=0 (zero fill).
//   - On each shift edge, sample tdo before the chain shifts. The i-th sample (i=0..N-1) goes to response[N-1-i].
//   - The first sample is taken on edge E(N+C+1).
//  DONE, cycle 2N+C+1: tms=0; done=1 for exactly one cycle; response and pass are updated on the edge entering DONE.
//  Latency: done is high in cycle 2N+2 after E0 with cap_en=1, or 2N+1 with cap_en=0. ready returns the next cycle.
//  response/pass hold their values until the next accept; on accept they are cleared to 0.
//  start while busy (ready=0) is ignored, not queued; a start held high re-triggers in the first IDLE cycle.
//  ClrN low mid-operation: abort at once; tms=0 and tdi=0 immediately; no done pulse; chain contents undefined.
//  Counter: counts 0..N-1 in each shift state; it moves to the next state when count==N-1, and wraps to 0 on every state change.
//  N=1: one shift-in, optional capture, one shift-out; all rules above still apply.
//  mask=0: pass=1 regardless of response.
// TESTING
//  1 Reset: ClrN=0 with start=1 -> ready=1, tms=0, tdi=0, done=0, pass=0, response=0; no accept until ClrN=1.
//  2 Shift-through: N=3 ideal chain model, cap_en=0, pattern=3'b101, expected=3'b101, mask=3'b111.
//    -> tdi sequence 1,0,1 with tms=1 for cycles 1-3; response=3'b101; pass=1; done in cycle 7.
//  3 Capture: N=3, cap_en=1, chain functional D=3'b011, pattern=3'b100, expected=3'b011.
//    -> tms=0 in cycle 4 only; response=3'b011; pass=1; done in cycle 8.
//  4 Mismatch and mask: capture of 3'b011 with expected=3'b111.
//    -> mask=3'b111 gives pass=0; the same run with mask=3'b011 gives pass=1; response=3'b011 in both.
//  5 Busy start: pulse start in cycles 2 and 6 of a run -> both ignored; exactly one done; ready=1 the cycle after done.
//  6 Abort: assert ClrN=0 in cycle 2 of SHIFT_IN -> tms=0 at once; no done; after release, a new run completes with the correct response.

Source files
------------

// File: rtl/scan_chain_driver.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_driver
//  Description : Tester-side initiator for a mux-scan chain. Loads an N-bit
//                pattern, optionally pulses one functional capture, unloads
//                N bits and compares them against an expected vector under a
//                mask. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_driver #(
  parameter int CHAIN_LEN = 3,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 Clk,
  input  logic                 ClrN,
  input  logic                 start,
  input  logic                 cap_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  output logic                 ready,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 done,
  output logic                 pass
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_shift_in  = 3'd1;
  localparam logic [2:0] c_st_capture   = 3'd2;
  localparam logic [2:0] c_st_shift_out = 3'd3;
  localparam logic [2:0] c_st_done      = 3'd4;

  // Terminal count of every shift phase.
  localparam logic [CW-1:0] c_last = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_mask;
  logic                 r_cap;
  logic [CHAIN_LEN-1:0] r_sh;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_pass;
  logic                 r_ready;
  logic                 r_tms;
  logic                 r_tdi;
  logic                 r_done;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [2:0]           w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_ready_nxt;
  logic                 w_tms_nxt;
  logic                 w_tdi_nxt;
  logic                 w_done_nxt;
  logic [CHAIN_LEN-1:0] w_tdi_src;
  logic [CW-1:0]        w_tdi_idx;
  logic [CHAIN_LEN:0]   w_unload_ext;
  logic [CHAIN_LEN-1:0] w_unload;
  logic                 w_pass_nxt;

  // A request is only taken while idle; anything else is dropped.
  assign w_accept = (r_state == c_st_idle) && start;
  assign w_last   = (r_cnt == c_last);

  // Unload shifter with the current tdo appended: the first sample ends up
  // in the MSB, the last one in bit 0. The extra bit keeps N=1 well formed.
  assign w_unload_ext = {r_sh, tdo};
  assign w_unload     = w_unload_ext[CHAIN_LEN-1:0];
  assign w_pass_nxt   = ~|((w_unload ^ r_exp) & r_mask);

  // State and phase counter register.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: each shift phase lasts exactly CHAIN_LEN cycles and the
  // counter restarts from zero whenever the phase changes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = c_st_shift_in;
        end
      end
      c_st_shift_in: begin
        if (w_last) begin
          w_state_nxt = r_cap ? c_st_capture : c_st_shift_out;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      c_st_capture: begin
        w_state_nxt = c_st_shift_out;
        w_cnt_nxt   = '0;
      end
      c_st_shift_out: begin
        if (w_last) begin
          w_state_nxt = c_st_done;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, so the pins are registered and line
  // up with the state they belong to. On the accept edge the pattern is not
  // latched yet, so the first scan bit is taken from the input port.
  always_comb begin
    w_tdi_src   = w_accept ? pattern : r_pat;
    w_tdi_idx   = c_last - w_cnt_nxt;
    w_ready_nxt = (w_state_nxt == c_st_idle);
    w_tms_nxt   = (w_state_nxt == c_st_shift_in) || (w_state_nxt == c_st_shift_out);
    w_tdi_nxt   = 1'b0;
    if (w_state_nxt == c_st_shift_in) begin
      w_tdi_nxt = w_tdi_src[w_tdi_idx];
    end
    w_done_nxt  = (w_state_nxt == c_st_done);
  end

  // Registered chain-control and handshake outputs.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_ready <= 1'b1;
      r_tms   <= 1'b0;
      r_tdi   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Capture the request operands on accept; inputs are don't-care afterwards.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_pat  <= '0;
      r_exp  <= '0;
      r_mask <= '0;
      r_cap  <= 1'b0;
    end else if (w_accept) begin
      r_pat  <= pattern;
      r_exp  <= expected;
      r_mask <= mask;
      r_cap  <= cap_en;
    end
  end

  // Sample tdo on every unload edge and publish the result on the edge that
  // enters DONE; the result is cleared when the next request is accepted.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_sh   <= '0;
      r_resp <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= '0;
      r_resp <= '0;
      r_pass <= 1'b0;
    end else if (r_state == c_st_shift_out) begin
      r_sh <= w_unload;
      if (w_last) begin
        r_resp <= w_unload;
        r_pass <= w_pass_nxt;
      end
    end
  end

  assign ready    = r_ready;
  assign tms      = r_tms;
  assign tdi      = r_tdi;
  assign done     = r_done;
  assign response = r_resp;
  assign pass     = r_pass;

endmodule
`default_nettype wire
